// File: rtl/sap_defs.sv
// Shared definitions for the SAP-II main-memory responder.
package sap_defs;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 4;

    localparam logic [DATA_W-1:0] HIGH_Z = 8'bz;
    localparam logic [DATA_W-1:0] ZERO   = 8'h00;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        DRIVE   = 3'd2,
        COMMIT  = 3'd3,
        RELEASE = 3'd4
    } state_e;

endpackage

// File: rtl/ram_array.sv
// Byte storage: one synchronous write port, one combinational read port.
module ram_array
    import sap_defs::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sap_ram.sv
// SAP-II memory responder: request FSM, wait-state counter and DATA bus tristate
// around a ram_array; RDY/ERR/bus-drive are registered off the FSM state.
module sap_ram
    import sap_defs::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              nCLR,
    input  logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA,
    input  logic              nRD,
    input  logic              nWR,
    output logic              RDY,
    output logic              ERR,
    input  logic              PROG_EN,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic               err_d;
    logic               rdy_q, drive_q, commit_q;

    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_waddr_c;
    logic [DATA_W-1:0]  mem_wdata_c;
    logic [DATA_W-1:0]  rdata_c;

    // State, transaction latches and the one-cycle output stage.
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_W'(0);
            addr_q   <= ADDR_W'(0);
            wdata_q  <= ZERO;
            is_wr_q  <= 1'b0;
            rdy_q    <= 1'b0;
            ERR      <= 1'b0;
            drive_q  <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            rdy_q    <= (state_q == DRIVE) || (state_q == COMMIT);
            ERR      <= err_d;
            drive_q  <= (state_q == DRIVE);
            commit_q <= (state_q == COMMIT);
        end
    end

    // Next-state logic; requests are only looked at in IDLE and RELEASE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!PROG_EN) begin
                    if (!nRD && !nWR) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end else if (!nRD || !nWR) begin
                        addr_d  = ADDR;
                        is_wr_d = !nWR;
                        cnt_d   = CNT_W'(WAIT_STATES);
                        if (!nWR) begin
                            wdata_d = DATA;
                        end
                        if (WAIT_STATES == 0) begin
                            state_d = !nWR ? COMMIT : DRIVE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = is_wr_q ? COMMIT : DRIVE;
                end
            end
            DRIVE, COMMIT: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (nRD && nWR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write port: front panel while idle in programming mode, else the delayed commit.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_q;
        mem_wdata_c = wdata_q;
        if ((state_q == IDLE) && PROG_EN) begin
            mem_we_c    = nCLR && PROG_WE;
            mem_waddr_c = PROG_ADDR;
            mem_wdata_c = PROG_DATA;
        end else begin
            mem_we_c    = nCLR && commit_q;
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W)
    ) u_ram_array (
        .CLK     (CLK),
        .we      (mem_we_c),
        .waddr   (mem_waddr_c),
        .wdata   (mem_wdata_c),
        .raddr   (addr_q),
        .rdata_c (rdata_c)
    );

    assign RDY  = rdy_q;
    assign DATA = drive_q ? rdata_c : HIGH_Z;

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: three instances with 0, 1 and 3 wait states.
module tb_sap_ram;

    // A released DATA bus floats up to all ones through the pullups.
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nclr;
    logic [15:0] addr [3];
    logic        nrd [3];
    logic        nwr [3];
    logic        prog_en [3];
    logic        prog_we [3];
    logic [15:0] prog_addr [3];
    logic [7:0]  prog_data [3];
    logic        rdy [3];
    logic        err [3];
    logic [7:0]  drv [3];
    logic        drv_en [3];

    wire [7:0] data0, data1, data2;
    assign data0 = drv_en[0] ? drv[0] : 8'bz;
    assign data1 = drv_en[1] ? drv[1] : 8'bz;
    assign data2 = drv_en[2] ? drv[2] : 8'bz;
    pullup (data0);
    pullup (data1);
    pullup (data2);

    sap_ram #(.ADDR_W(16), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .nCLR(nclr), .ADDR(addr[0]), .DATA(data0), .nRD(nrd[0]), .nWR(nwr[0]),
        .RDY(rdy[0]), .ERR(err[0]), .PROG_EN(prog_en[0]), .PROG_WE(prog_we[0]),
        .PROG_ADDR(prog_addr[0]), .PROG_DATA(prog_data[0]));
    sap_ram #(.ADDR_W(16), .WAIT_STATES(1)) u_ws1 (
        .CLK(clk), .nCLR(nclr), .ADDR(addr[1]), .DATA(data1), .nRD(nrd[1]), .nWR(nwr[1]),
        .RDY(rdy[1]), .ERR(err[1]), .PROG_EN(prog_en[1]), .PROG_WE(prog_we[1]),
        .PROG_ADDR(prog_addr[1]), .PROG_DATA(prog_data[1]));
    sap_ram #(.ADDR_W(16), .WAIT_STATES(3)) u_ws3 (
        .CLK(clk), .nCLR(nclr), .ADDR(addr[2]), .DATA(data2), .nRD(nrd[2]), .nWR(nwr[2]),
        .RDY(rdy[2]), .ERR(err[2]), .PROG_EN(prog_en[2]), .PROG_WE(prog_we[2]),
        .PROG_ADDR(prog_addr[2]), .PROG_DATA(prog_data[2]));

    typedef struct {
        bit         wr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         dut;
        bit         wr;
        logic [15:0] a;
        logic [7:0] d;      // write data, or expected read data
        bit         glitch; // change DATA right after the write is accepted
    } vec_t;

    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic logic [7:0] bus(input int d);
        case (d)
            0:       return data0;
            1:       return data1;
            default: return data2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic prog(input int d, input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        prog_en[d] = 1'b1; prog_we[d] = 1'b1; prog_addr[d] = a; prog_data[d] = v;
        @(negedge clk);
        prog_en[d] = 1'b0; prog_we[d] = 1'b0;
    endtask

    // Issue one request at the current negedge; returns at the negedge where the next may start.
    task automatic txn(input int d, input bit wr, input logic [15:0] a, input logic [7:0] v,
                       input bit glitch, input int hold);
        exp_t e;
        bit   found;
        int   ws;
        ws     = ws_of(d);
        e.wr   = wr;
        e.data = wr ? 8'h00 : v;
        sb.push_back(e);
        addr[d] = a;
        if (wr) begin
            drv[d] = v; drv_en[d] = 1'b1; nwr[d] = 1'b0;
        end else begin
            nrd[d] = 1'b0;
        end
        found = 1'b0;
        for (int k = 1; k <= ws + 6 && !found; k++) begin
            @(negedge clk);
            if (wr && glitch && k == 1) drv[d] = 8'hFF;
            if (rdy[d]) begin
                found = 1'b1;
                check("rdy_latency", k, ws + 2);
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (!e.wr) check("read_data", bus(d), e.data);
                end
            end else if (!wr) begin
                check("bus_released_wait", bus(d), BUS_IDLE);
            end
        end
        if (!found) check("rdy_timeout", 0, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("no_second_rdy", rdy[d], 1'b0);
            check("bus_released_hold", bus(d), BUS_IDLE);
        end
        nrd[d] = 1'b1; nwr[d] = 1'b1; drv_en[d] = 1'b0;
        @(negedge clk);
        check("rdy_after_release", rdy[d], 1'b0);
        check("bus_released_after", bus(d), BUS_IDLE);
    endtask

    vec_t vecs [10];
    int   errcnt;

    initial begin
        vecs[0] = '{1, 1'b0, 16'h0010, 8'h25, 1'b0};
        vecs[1] = '{1, 1'b1, 16'h0020, 8'h37, 1'b1};
        vecs[2] = '{1, 1'b0, 16'h0020, 8'h37, 1'b0};
        vecs[3] = '{0, 1'b0, 16'h0010, 8'h25, 1'b0};
        vecs[4] = '{0, 1'b1, 16'h0030, 8'h5A, 1'b0};
        vecs[5] = '{0, 1'b0, 16'h0030, 8'h5A, 1'b0};
        vecs[6] = '{0, 1'b1, 16'hFFFF, 8'hC3, 1'b0};
        vecs[7] = '{0, 1'b0, 16'hFFFF, 8'hC3, 1'b0};
        vecs[8] = '{2, 1'b1, 16'h0020, 8'h37, 1'b0};
        vecs[9] = '{2, 1'b0, 16'h0020, 8'h37, 1'b0};

        nclr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 16'h0000; nrd[i] = 1'b1; nwr[i] = 1'b1;
            prog_en[i] = 1'b0; prog_we[i] = 1'b0; prog_addr[i] = 16'h0000;
            prog_data[i] = 8'h00; drv[i] = 8'h00; drv_en[i] = 1'b0;
        end
        nrd[0] = 1'b0;

        // Reset held with a read pending.
        repeat (2) begin
            @(negedge clk);
            check("reset_rdy", rdy[0], 1'b0);
            check("reset_err", err[0], 1'b0);
            check("reset_bus", bus(0), BUS_IDLE);
        end
        nrd[0] = 1'b1;
        nclr   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_rdy", rdy[0], 1'b0);
        end

        prog(1, 16'h0010, 8'h25);
        prog(0, 16'h0010, 8'h25);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].dut, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].glitch, 0);
        end

        // Read held low: exactly one RDY.
        txn(1, 1'b0, 16'h0010, 8'h25, 1'b0, 5);

        // Conflicting requests.
        addr[1] = 16'h0020; nrd[1] = 1'b0; nwr[1] = 1'b0;
        errcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (err[1]) errcnt++;
            check("conflict_no_rdy", rdy[1], 1'b0);
            check("conflict_bus", bus(1), BUS_IDLE);
        end
        check("conflict_err_pulses", errcnt, 1);
        nrd[1] = 1'b1; nwr[1] = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 16'h0020, 8'h37, 1'b0, 0);

        // Reset during the wait states of a write.
        addr[2] = 16'h0020; drv[2] = 8'h99; drv_en[2] = 1'b1; nwr[2] = 1'b0;
        @(negedge clk);
        check("midwrite_rdy0", rdy[2], 1'b0);
        @(negedge clk);
        check("midwrite_rdy1", rdy[2], 1'b0);
        nclr = 1'b0;
        @(negedge clk);
        nclr = 1'b1; nwr[2] = 1'b1; drv_en[2] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("midwrite_no_rdy", rdy[2], 1'b0);
        end
        txn(2, 1'b0, 16'h0020, 8'h37, 1'b0, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_ram.md
# sap_ram

Byte-wide main-memory responder for the SAP-II datapath: the memory-side end of the memory data register's 8-bit `DATA` bus. It takes the address from the memory address register and serves read and write requests from the control sequencer. A read drives a stored byte onto the shared `DATA` bus for the data register to load. A write captures the byte the data register drives and commits it after a configurable number of wait states. A front-panel programming port loads memory before a run.

## Interface
Parameters:
- `ADDR_W`, 16: address width; depth is 2**`ADDR_W` bytes.
- `WAIT_STATES`, 1: cycles inserted between request acceptance and completion (0–15).

Ports:
- `CLK`  in  1: clock; everything is on the rising edge.
- `nCLR`  in  1: reset, synchronous, active-low.
- `ADDR`  in  `ADDR_W`: address from the memory address register.
- `DATA`  inout  8: shared bus with the memory data register. Driven only in `DRIVE`, high-Z otherwise.
- `nRD`  in  1: read request, active-low, level.
- `nWR`  in  1: write request, active-low, level.
- `RDY`  out  1: one-cycle completion strobe.
- `ERR`  out  1: one-cycle strobe when `nRD` and `nWR` are both low at acceptance.
- `PROG_EN`  in  1: programming mode.
- `PROG_WE`  in  1: programming write strobe.
- `PROG_ADDR`  in  `ADDR_W`: programming address.
- `PROG_DATA`  in  8: programming data.

## Operation
- States: `IDLE`, `WAIT`, `DRIVE`, `COMMIT`, `RELEASE`.
- **IDLE:**
  - If `PROG_EN`=1, bus requests are not accepted. `PROG_WE`=1 writes `PROG_DATA` to `mem[PROG_ADDR]` at the edge.
  - If `PROG_EN`=0 and exactly one request is low at the edge, latch `ADDR` into `addr_q`. For a write, also latch `DATA` into `wdata_q`. Load `WAIT_STATES` into the wait counter.
  - Next state is `WAIT`, or `DRIVE`/`COMMIT` directly if `WAIT_STATES`=0.
  - Both requests low: pulse `ERR`, go to `RELEASE`, leave memory unchanged.
- **WAIT:** decrement the counter each cycle. At 1, go to `DRIVE` (read) or `COMMIT` (write). Changes on `ADDR`, `DATA` or the requests are ignored here.
- **DRIVE:** `DATA`=`mem[addr_q]`, `RDY`=1. Next state is `RELEASE`.
- **COMMIT:** `RDY`=1. `mem[addr_q]`←`wdata_q` at the exiting edge. Next state is `RELEASE`.
- **RELEASE:** stay until `nRD`=`nWR`=1 is sampled, then go to `IDLE`. A request held low does not re-issue.
- A `PROG_EN` rise mid-transaction has no effect until the FSM returns to `IDLE`.
- Addresses are used modulo 2**`ADDR_W`; no bounds error.

## Timing
- **Reset values:** state `IDLE`, `RDY`=0, `ERR`=0, `DATA`=Z, counter 0, `addr_q`/`wdata_q` 0. Memory contents are not cleared.
- **Reset mid-transaction:** the transaction is aborted, a pending write is not committed, and `RDY` is not asserted.
- **Request latency:** with the request sampled at edge E0, `RDY` is high from edge E0+`WAIT_STATES`+1 to E0+`WAIT_STATES`+2, exactly one cycle.
- **Read:** `DATA` is valid for the same cycle as `RDY`. The data register loads at the edge that ends it.
- **Write:** `mem` updates at the edge ending the `RDY` cycle. A read accepted later returns the new byte.
- **Minimum throughput:** one transaction per `WAIT_STATES`+3 cycles, which includes the `RELEASE` cycle.
- `ERR` is high during the cycle after E0.

## Structure
- **Shared `sap_defs` package:**
  - state encodings (3-bit)
  - `DATA_W`=8
  - `HIGH_Z`=8'bz
  - `ZERO`=8'h00
- **Sub-module `ram_array`:** parameterised storage with one synchronous write port and one combinational read port.
  - Write-port mux: programming port in `IDLE`/`PROG_EN`, otherwise `COMMIT`.
  - The FSM, wait counter and tristate stay in `sap_ram`.

## Test plan
1. **Reset:** `nCLR`=0 for 2 cycles with `nRD`=0 → `RDY`=0, `ERR`=0, `DATA`=Z, no transaction starts.
2. **Programming then read:** `PROG_EN`=1, `PROG_WE`=1, `PROG_ADDR`=16'h0010, `PROG_DATA`=8'h25 for one cycle. Then `PROG_EN`=0, `ADDR`=16'h0010, `nRD`=0 at E0, `WAIT_STATES`=1 → `RDY` and `DATA`=8'h25 only during E0+2..E0+3, `DATA` Z otherwise. Holding `nRD` low for 5 more cycles gives no second `RDY`.
3. **Write:** bench drives `DATA`=8'h37, `ADDR`=16'h0020, `nWR`=0 at E0. It then changes `DATA` to 8'hFF at E0+1 → one `RDY` at E0+2. A later read of 16'h0020 returns 8'h37.
4. **Zero wait states** (`WAIT_STATES`=0): read accepted at E0 → `RDY` during E0+1..E0+2. Back-to-back read, write, read with release cycles each complete in 3 cycles.
5. **Conflict:** `nRD`=`nWR`=0 at 16'h0020 → `ERR` for one cycle, no `RDY`, `DATA` stays Z, 16'h0020 still reads 8'h37.
6. **Reset mid-write:** write 8'h99 to 16'h0020 with `WAIT_STATES`=3, `nCLR`=0 at E0+2 → no `RDY`, and 16'h0020 reads 8'h37 afterwards.
